vga_rd_scheduler: RTL

Read-side scheduler between the VGA timing driver and the SDRAM controller's read port. It turns frame-start and address-reset pulses plus read-FIFO occupancy into a stream of burst read requests covering one full frame. It also selects between two ping-pong frame buffers so the display never reads a frame the writer is still filling. It sits in the `clk_vga` domain beside the VGA driver; the SDRAM read port is presented synchronous to `clk_vga`.

---
 rtl/vga_rd_scheduler_pkg.sv | 34 +++
 rtl/vga_rd_scheduler_if.sv | 31 +++
 rtl/vga_rd_scheduler_buf_sel.sv | 52 +++++
 rtl/vga_rd_scheduler.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/vga_rd_scheduler_pkg.sv
// -----------------------------------------------------------------------------
// vga_rd_pkg
//   Shared types and constants for the VGA read-side scheduler.
//   - state_e      : scheduler FSM states
//   - FRAME_WORDS  : words in one frame at the default 640x480 geometry
//   - LEN_W        : width of the burst-length field on the SDRAM read port
//   - WL_W         : width of the words-left counter
//   - next_len()   : size of the next burst, min(burst_max, words_left)
// -----------------------------------------------------------------------------
package vga_rd_pkg;

    localparam int DEF_H_PIXELS = 640;
    localparam int DEF_V_LINES  = 480;
    localparam int FRAME_WORDS  = DEF_H_PIXELS * DEF_V_LINES;

    localparam int LEN_W = 9;   // holds 1..256
    localparam int WL_W  = 20;  // holds a full 640x480 frame

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FLUSH1,
        ST_FLUSH2,
        ST_WAIT,
        ST_REQ,
        ST_BURST,
        ST_DONE
    } state_e;

    function automatic logic [LEN_W-1:0] next_len(input logic [WL_W-1:0] words_left,
                                                  input logic [WL_W-1:0] burst_max);
        return LEN_W'((words_left < burst_max) ? words_left : burst_max);
    endfunction

endpackage

// File: rtl/vga_rd_scheduler_if.sv
// -----------------------------------------------------------------------------
// vga_rd_scheduler_if
//   SDRAM controller read-request port, synchronous to clk_vga.
//   rd_req  : request, held until rd_ack is sampled
//   rd_addr : burst start word address, stable while rd_req is high
//   rd_len  : burst length in words, stable while rd_req is high
//   rd_ack  : request accepted
//   rd_done : last word of the burst has been written to the read FIFO
//   master = scheduler side, slave = SDRAM controller side.
// -----------------------------------------------------------------------------
interface vga_rd_scheduler_if
    import vga_rd_pkg::*;
#(
    parameter int ADDR_W = 22
);
    logic              rd_req;
    logic [ADDR_W-1:0] rd_addr;
    logic [LEN_W-1:0]  rd_len;
    logic              rd_ack;
    logic              rd_done;

    modport master (
        output rd_req, rd_addr, rd_len,
        input  rd_ack, rd_done
    );

    modport slave (
        input  rd_req, rd_addr, rd_len,
        output rd_ack, rd_done
    );
endinterface

// File: rtl/vga_rd_scheduler_buf_sel.sv
// -----------------------------------------------------------------------------
// vga_buf_sel
//   Ping-pong frame buffer selection. Remembers that the writer finished a
//   frame (swap pending) and toggles the displayed buffer only when a frame
//   restart caused by vga_framesync is applied.
//   clk_vga, vga_rst_n : clock, async active-low reset
//   wr_frame_done_i    : writer completed a frame
//   apply_i            : a restart is being applied this cycle
//   apply_sync_i       : that restart includes a vga_framesync (swap allowed)
//   frame_sel_o        : buffer being displayed (registered)
//   base_addr_o        : base address of the buffer the restart will read
// -----------------------------------------------------------------------------
module vga_buf_sel #(
    parameter int                ADDR_W = 22,
    parameter logic [ADDR_W-1:0] BASE0  = '0,
    parameter logic [ADDR_W-1:0] BASE1  = '0
) (
    input  logic              clk_vga,
    input  logic              vga_rst_n,
    input  logic              wr_frame_done_i,
    input  logic              apply_i,
    input  logic              apply_sync_i,
    output logic              frame_sel_o,
    output logic [ADDR_W-1:0] base_addr_o
);

    logic swap_pend_q, swap_pend_d;
    logic frame_sel_q, frame_sel_d;
    logic swap_take;

    always_comb begin
        // A frame-done arriving in the same cycle as the restart still counts.
        swap_take   = apply_i & apply_sync_i & (swap_pend_q | wr_frame_done_i);
        frame_sel_d = frame_sel_q ^ swap_take;
        swap_pend_d = (swap_pend_q | wr_frame_done_i) & ~swap_take;
        // The restart loads the base of the buffer selected after the swap.
        base_addr_o = frame_sel_d ? BASE1 : BASE0;
    end

    always_ff @(posedge clk_vga or negedge vga_rst_n) begin
        if (!vga_rst_n) begin
            swap_pend_q <= 1'b0;
            frame_sel_q <= 1'b0;
        end else begin
            swap_pend_q <= swap_pend_d;
            frame_sel_q <= frame_sel_d;
        end
    end

    assign frame_sel_o = frame_sel_q;

endmodule

// File: rtl/vga_rd_scheduler.sv
// -----------------------------------------------------------------------------
// vga_rd_scheduler
//   Turns frame-start / address-reset pulses and read-FIFO occupancy into a
//   stream of SDRAM burst read requests covering one frame, reading from the
//   ping-pong buffer chosen by vga_buf_sel.
//   clk_vga, vga_rst_n : clock, async active-low reset
//   vga_framesync      : frame start pulse (restart, may swap buffers)
//   sdr_addr_set       : restart the current buffer (never swaps)
//   wr_frame_done      : writer finished a frame
//   vga_rden           : driver popping the read FIFO
//   fifo_usedw         : read FIFO word count
//   fifo_flush         : one-cycle read FIFO clear
//   frame_sel          : buffer being displayed
//   underflow          : pop attempted on an empty FIFO (one cycle later)
//   rd                 : SDRAM read-request port (master side)
// -----------------------------------------------------------------------------
module vga_rd_scheduler
    import vga_rd_pkg::*;
#(
    parameter int   H_PIXELS   = DEF_H_PIXELS,
    parameter int   V_LINES    = DEF_V_LINES,
    parameter int   BURST_LEN  = 256,
    parameter int   FIFO_DEPTH = 1024,
    parameter int   ADDR_W     = 22,
    parameter int   BASE0      = 0,
    parameter int   BASE1      = 'h80000,
    localparam int  FW         = $clog2(FIFO_DEPTH) + 1
) (
    input  logic              clk_vga,
    input  logic              vga_rst_n,
    input  logic              vga_framesync,
    input  logic              sdr_addr_set,
    input  logic              wr_frame_done,
    input  logic              vga_rden,
    input  logic [FW-1:0]     fifo_usedw,
    output logic              fifo_flush,
    output logic              frame_sel,
    output logic              underflow,
    vga_rd_scheduler_if.master rd
);

    localparam logic [WL_W-1:0] FRAME_W = WL_W'(H_PIXELS * V_LINES);
    localparam logic [WL_W-1:0] BURST_W = WL_W'(BURST_LEN);
    localparam logic [FW:0]     DEPTH_W = (FW+1)'(FIFO_DEPTH);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [WL_W-1:0]   words_left_q, words_left_d;
    logic [LEN_W-1:0]  len_q, len_d;
    logic              restart_pend_q, restart_pend_d;
    logic              pend_sync_q, pend_sync_d;
    logic              underflow_q;

    logic              r_now;
    logic              apply, apply_sync;
    logic [ADDR_W-1:0] base_addr;
    logic [LEN_W-1:0]  len_next;
    logic [FW:0]       room;
    logic              fits;

    vga_buf_sel #(
        .ADDR_W (ADDR_W),
        .BASE0  (ADDR_W'(BASE0)),
        .BASE1  (ADDR_W'(BASE1))
    ) u_buf_sel (
        .clk_vga         (clk_vga),
        .vga_rst_n       (vga_rst_n),
        .wr_frame_done_i (wr_frame_done),
        .apply_i         (apply),
        .apply_sync_i    (apply_sync),
        .frame_sel_o     (frame_sel),
        .base_addr_o     (base_addr)
    );

    // NOTE: every signal written in always_comb gets a default first, so no
    // path through the case statements can leave a latch behind.
    always_comb begin
        state_d        = state_q;
        addr_d         = addr_q;
        words_left_d   = words_left_q;
        len_d          = len_q;
        restart_pend_d = restart_pend_q;
        pend_sync_d    = pend_sync_q;
        apply          = 1'b0;
        apply_sync     = 1'b0;

        // Simultaneous framesync and addr_set collapse into one restart.
        r_now    = vga_framesync | sdr_addr_set;
        len_next = next_len(words_left_q, BURST_W);
        room     = DEPTH_W - {1'b0, fifo_usedw};
        fits     = WL_W'(room) >= WL_W'(len_next);

        if (state_q == ST_REQ || state_q == ST_BURST) begin
            // A request in flight is never aborted; a restart is parked
            // until its burst completes.
            if (r_now) begin
                restart_pend_d = 1'b1;
                pend_sync_d    = pend_sync_q | vga_framesync;
            end
            if (state_q == ST_REQ) begin
                // rd_done coinciding with rd_ack is deliberately ignored.
                if (rd.rd_ack) state_d = ST_BURST;
            end else if (rd.rd_done) begin
                addr_d       = addr_q + ADDR_W'(len_q);
                words_left_d = words_left_q - WL_W'(len_q);
                if (restart_pend_q || r_now) begin
                    apply          = 1'b1;
                    apply_sync     = pend_sync_q | vga_framesync;
                    restart_pend_d = 1'b0;
                    pend_sync_d    = 1'b0;
                    state_d        = ST_FLUSH1;
                end else begin
                    state_d = ST_WAIT;
                end
            end
        end else if (r_now) begin
            apply      = 1'b1;
            apply_sync = vga_framesync;
            state_d    = ST_FLUSH1;
        end else begin
            case (state_q)
                ST_FLUSH1: state_d = ST_FLUSH2;
                ST_FLUSH2: state_d = ST_WAIT;   // let fifo_usedw settle after the clear
                ST_WAIT: begin
                    if (words_left_q == '0) begin
                        state_d = ST_DONE;
                    end else if (fits) begin
                        len_d   = len_next;
                        state_d = ST_REQ;
                    end
                end
                default: ;                      // IDLE and DONE wait for a restart
            endcase
        end

        if (apply) begin
            addr_d       = base_addr;
            words_left_d = FRAME_W;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of block ordering.
    always_ff @(posedge clk_vga or negedge vga_rst_n) begin
        if (!vga_rst_n) begin
            state_q        <= ST_IDLE;
            addr_q         <= '0;
            words_left_q   <= '0;
            len_q          <= '0;
            restart_pend_q <= 1'b0;
            pend_sync_q    <= 1'b0;
            underflow_q    <= 1'b0;
        end else begin
            state_q        <= state_d;
            addr_q         <= addr_d;
            words_left_q   <= words_left_d;
            len_q          <= len_d;
            restart_pend_q <= restart_pend_d;
            pend_sync_q    <= pend_sync_d;
            underflow_q    <= vga_rden & (fifo_usedw == '0);
        end
    end

    // All outputs decode registers only; nothing depends combinationally on rd_ack.
    assign fifo_flush = (state_q == ST_FLUSH1);
    assign rd.rd_req  = (state_q == ST_REQ);
    assign rd.rd_addr = addr_q;
    assign rd.rd_len  = len_q;
    assign underflow  = underflow_q;

endmodule
